// File: rtl/shift_74hc165.sv
// Reader for a chain of 74HC165 PISO shift registers: load, clock out WIDTH bits, present the word.
// Optional SHIFT_165_CHANGE_EN adds a `changed` pulse when a capture differs from the previous word.
module shift_74hc165 #(
    parameter int CHAIN   = 1,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 serial_in,
    output logic                 shift_load_n,
    output logic                 shift_clock,
    output logic [8*CHAIN-1:0]   data_out,
    output logic                 valid,
    output logic                 busy
`ifdef SHIFT_165_CHANGE_EN
   ,output logic                 changed
`endif
);

    localparam int WIDTH = 8 * CHAIN;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_q, div_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic [WIDTH-1:0] shreg_q, shreg_next;
    logic             div_end;
    logic             sample;
    logic             load_n_next;
    logic             sclk_next;
    logic             busy_next;
    logic             valid_next;

    assign div_end = (div_q == DIV_LAST);

    // Pins are driven from registers loaded with the decode of the next state,
    // so they track the state register cycle-for-cycle without glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            shift_load_n <= 1'b1;
            shift_clock  <= 1'b0;
            data_out     <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
`ifdef SHIFT_165_CHANGE_EN
            changed      <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            div_q        <= div_next;
            cnt_q        <= cnt_next;
            shreg_q      <= shreg_next;
            shift_load_n <= load_n_next;
            shift_clock  <= sclk_next;
            valid        <= valid_next;
            busy         <= busy_next;
            if (valid_next) begin
                data_out <= shreg_next;
            end
`ifdef SHIFT_165_CHANGE_EN
            changed      <= valid_next && (shreg_next != data_out);
`endif
        end
    end

    always_comb begin
        state_next = state;
        div_next   = div_q + 1'b1;
        cnt_next   = cnt_q;
        sample     = 1'b0;
        case (state)
            S_IDLE: begin
                div_next = '0;
                if (rd_en) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (div_end) begin
                    div_next   = '0;
                    state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (div_end) begin
                    div_next   = '0;
                    sample     = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_end) begin
                    div_next   = '0;
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (div_end) begin
                    div_next   = '0;
                    sample     = 1'b1;
                    cnt_next   = cnt_q + 1'b1;
                    state_next = (cnt_q == CNT_LAST) ? S_DONE : S_HIGH;
                end
            end
            S_DONE: begin
                div_next   = '0;
                state_next = rd_en ? S_LOAD : S_IDLE;
            end
            default: begin
                div_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Left shift: after WIDTH samples the first bit (nearest chip's D7) sits in the MSB.
    always_comb begin
        shreg_next = shreg_q;
        if (sample) shreg_next = {shreg_q[WIDTH-2:0], serial_in};
    end

    always_comb begin
        load_n_next = (state_next != S_LOAD);
        sclk_next   = (state_next == S_HIGH);
        busy_next   = (state_next inside {S_LOAD, S_SETTLE, S_HIGH, S_LOW});
        valid_next  = (state_next == S_DONE);
    end

endmodule

// File: tb/tb_shift_74hc165.sv
// Self-checking bench: two readers (1 and 2 chips) driven by a behavioural 74HC165 chain model.
module tb_shift_74hc165;

    localparam int CLK_DIV = 4;
    localparam int W1      = 8;
    localparam int W2      = 16;
    localparam int LAT1    = 2 * CLK_DIV * W1;
    localparam int LAT2    = 2 * CLK_DIV * W2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          rd1 = 1'b0, si1, ld1, sc1, v1, b1;
    logic [W1-1:0] do1;
    logic          rd2 = 1'b0, si2, ld2, sc2, v2, b2;
    logic [W2-1:0] do2;
`ifdef SHIFT_165_CHANGE_EN
    logic          ch1, ch2;
`endif

    always #5 clk = ~clk;

    shift_74hc165 #(.CHAIN(1), .CLK_DIV(CLK_DIV)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .serial_in(si1),
        .shift_load_n(ld1), .shift_clock(sc1), .data_out(do1), .valid(v1), .busy(b1)
`ifdef SHIFT_165_CHANGE_EN
       ,.changed(ch1)
`endif
    );

    shift_74hc165 #(.CHAIN(2), .CLK_DIV(CLK_DIV)) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd2), .serial_in(si2),
        .shift_load_n(ld2), .shift_clock(sc2), .data_out(do2), .valid(v2), .busy(b2)
`ifdef SHIFT_165_CHANGE_EN
       ,.changed(ch2)
`endif
    );

    // Chain model: PL low loads the parallel pins, a CP rising edge shifts toward Q7 (DS tied low).
    logic [W1-1:0] w1 = '0, s1 = '0;
    logic [W2-1:0] w2 = '0, s2 = '0;
    logic          sc1_p = 1'b0, sc2_p = 1'b0;
    int            cp1 = 0, ldc1 = 0, vc1 = 0;
    int            cp2 = 0, ldc2 = 0, vc2 = 0;

    always @(negedge clk) begin
        if (!ld1) s1 <= w1;
        else if (sc1 && !sc1_p) begin
            s1  <= {s1[W1-2:0], 1'b0};
            cp1 <= cp1 + 1;
        end
        sc1_p <= sc1;
        if (!ld1) ldc1 <= ldc1 + 1;
        if (v1) vc1 <= vc1 + 1;
    end

    always @(negedge clk) begin
        if (!ld2) s2 <= w2;
        else if (sc2 && !sc2_p) begin
            s2  <= {s2[W2-2:0], 1'b0};
            cp2 <= cp2 + 1;
        end
        sc2_p <= sc2;
        if (!ld2) ldc2 <= ldc2 + 1;
        if (v2) vc2 <= vc2 + 1;
    end

    assign si1 = s1[W1-1];
    assign si2 = s2[W2-1];

    int checks   = 0;
    int failures = 0;
    logic [W1-1:0] last1 = '0;
    logic [W2-1:0] last2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Counts edges (including the one that samples rd_en) until valid is seen at a falling edge.
    task automatic wait_v1(input bit poke, output int e, output bit stable);
        logic [W1-1:0] hold;
        hold   = do1;
        e      = 0;
        stable = 1'b1;
        while (e < LAT1 + 20) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (v1) break;
            if (do1 !== hold || !b1) stable = 1'b0;
            rd1 = poke && (e == 10 || e == 40);
        end
        rd1 = 1'b0;
    endtask

    task automatic cap1(input logic [W1-1:0] word, input logic [W1-1:0] exp_data, input bit poke);
        int e, cp0, ld0, vc0;
        bit stable;
        logic exp_ch;
        exp_ch = (exp_data != last1);
        @(negedge clk);
        #1;
        w1  = word;
        rd1 = 1'b1;
        cp0 = cp1; ld0 = ldc1; vc0 = vc1;
        wait_v1(poke, e, stable);
        chk("c1_latency", e, LAT1 + 1);
        chk("c1_data", {24'h0, do1}, {24'h0, exp_data});
        chk("c1_busy_at_valid", {31'h0, b1}, 32'd0);
        chk("c1_hold_busy", {31'h0, stable}, 32'd1);
`ifdef SHIFT_165_CHANGE_EN
        chk("c1_changed", {31'h0, ch1}, {31'h0, exp_ch});
`endif
        #1;
        chk("c1_cp_edges", cp1 - cp0, W1 - 1);
        repeat (poke ? 70 : 3) @(negedge clk);
        #1;
        chk("c1_valid_count", vc1 - vc0, 1);
        chk("c1_load_cycles", ldc1 - ld0, CLK_DIV);
        last1 = exp_data;
    endtask

    task automatic cap2(input logic [W2-1:0] word);
        int e, cp0, ld0, vc0;
        bit stable;
        logic [W2-1:0] hold;
        logic exp_ch;
        exp_ch = (word != last2);
        @(negedge clk);
        #1;
        w2     = word;
        rd2    = 1'b1;
        cp0    = cp2; ld0 = ldc2; vc0 = vc2;
        hold   = do2;
        e      = 0;
        stable = 1'b1;
        while (e < LAT2 + 20) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            rd2 = 1'b0;
            if (v2) break;
            if (do2 !== hold || !b2) stable = 1'b0;
        end
        chk("c2_latency", e, LAT2 + 1);
        chk("c2_data", {16'h0, do2}, {16'h0, word});
        chk("c2_busy_at_valid", {31'h0, b2}, 32'd0);
        chk("c2_hold_busy", {31'h0, stable}, 32'd1);
`ifdef SHIFT_165_CHANGE_EN
        chk("c2_changed", {31'h0, ch2}, {31'h0, exp_ch});
`endif
        #1;
        chk("c2_cp_edges", cp2 - cp0, W2 - 1);
        repeat (3) @(negedge clk);
        #1;
        chk("c2_valid_count", vc2 - vc0, 1);
        chk("c2_load_cycles", ldc2 - ld0, CLK_DIV);
        last2 = word;
    endtask

    typedef struct {
        logic [W1-1:0] word;
        logic [W1-1:0] exp_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   e, vc0, ld0;
        bit   stable;
        logic [W1-1:0] wa, wb;

        tbl[0] = '{8'h00, 8'h00};
        tbl[1] = '{8'h00, 8'h00};
        tbl[2] = '{8'h5A, 8'h5A};
        tbl[3] = '{8'hA5, 8'hA5};
        tbl[4] = '{8'hA5, 8'hA5};
        tbl[5] = '{8'hFF, 8'hFF};
        tbl[6] = '{8'h01, 8'h01};
        tbl[7] = '{8'h80, 8'h80};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load_n", {31'h0, ld1}, 32'd1);
        chk("rst_sclk", {31'h0, sc1}, 32'd0);
        chk("rst_data", {24'h0, do1}, 32'd0);
        chk("rst_valid", {31'h0, v1}, 32'd0);
        chk("rst_busy", {31'h0, b1}, 32'd0);
        chk("rst_data2", {16'h0, do2}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) cap1(tbl[i].word, tbl[i].exp_data, 1'b0);

        // rd_en pulses mid-capture must be dropped
        cap1(8'h3C, 8'h3C, 1'b1);

        // back-to-back: rd_en held during DONE restarts the load immediately
        wa = 8'h69;
        wb = 8'h96;
        @(negedge clk);
        #1;
        w1  = wa;
        rd1 = 1'b1;
        wait_v1(1'b0, e, stable);
        chk("b2b_first_data", {24'h0, do1}, {24'h0, wa});
        w1  = wb;
        rd1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_load_n_next", {31'h0, ld1}, 32'd0);
        #1;
        ld0 = ldc1;
        rd1 = 1'b0;
        wait_v1(1'b0, e, stable);
        chk("b2b_gap", e + 1, LAT1 + 1);
        chk("b2b_second_data", {24'h0, do1}, {24'h0, wb});
        #1;
        chk("b2b_load_cycles", ldc1 - ld0 + 1, CLK_DIV);
        last1 = wb;
        repeat (3) @(negedge clk);

        cap2(16'h3CC3);
        for (int i = 0; i < 8; i++) cap2(16'($urandom_range(0, 65535)));

        // asynchronous reset during a capture
        @(negedge clk);
        #1;
        w1  = 8'hC7;
        rd1 = 1'b1;
        @(posedge clk);
        #1;
        rd1 = 1'b0;
        repeat (26) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_sclk", {31'h0, sc1}, 32'd1);
        #1;
        vc0 = vc1;
        rst = 1'b1;
        #1;
        chk("arst_load_n", {31'h0, ld1}, 32'd1);
        chk("arst_sclk", {31'h0, sc1}, 32'd0);
        chk("arst_data", {24'h0, do1}, 32'd0);
        chk("arst_busy", {31'h0, b1}, 32'd0);
        chk("arst_valid", {31'h0, v1}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        last1 = '0;
        last2 = '0;
        repeat (80) @(negedge clk);
        #1;
        chk("arst_no_valid", vc1 - vc0, 0);
        cap1(8'hC7, 8'hC7, 1'b0);
        cap1(8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
